// File: rtl/serializer_8b.sv
// Output-stage serializer: 8-bit word + valid -> MSB-first bit stream with idle/sync insertion.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit, making 9-bit frames.
module serializer_8b #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       load_req,
    output logic       data_out,
    output logic       frame_start,
    output logic       active
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = 9;
    localparam int CNT_W     = 4;
`else
    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 3;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [3:0]       SYNC_LAST = 4'(SYNC_COUNT - 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

`ifdef SERIALIZER_PARITY_EN
    function automatic logic even_parity(input logic [7:0] word);
        even_parity = ^word;
    endfunction

    function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] word);
        make_frame = {word, even_parity(word)};
    endfunction
`else
    function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] word);
        make_frame = word;
    endfunction
`endif

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [CNT_W-1:0]       bit_cnt_s;
    logic [3:0]             sync_cnt_r;
    logic [3:0]             sync_cnt_s;
    logic [FRAME_LEN-1:0]   shreg_r;
    logic [FRAME_LEN-1:0]   shreg_s;
    logic [FRAME_LEN-1:0]   sample_s;
    logic                   frame_end_s;
    logic                   load_req_r;
    logic                   frame_start_r;
    logic                   active_r;

    // Next-state, counter and shift-register update logic.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        sync_cnt_s  = sync_cnt_r;
        shreg_s     = {shreg_r[FRAME_LEN-2:0], 1'b0};
        frame_end_s = (state_r != ST_RESET) && (bit_cnt_r == LAST_BIT);
        sample_s    = make_frame(valid_in ? data_in : IDLE_SYM);

        case (state_r)
            ST_RESET: begin
                state_s    = ST_SYNC;
                shreg_s    = make_frame(IDLE_SYM);
                bit_cnt_s  = {CNT_W{1'b0}};
                sync_cnt_s = 4'd0;
            end
            ST_SYNC: begin
                if (frame_end_s) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    // The last sync frame's closing edge already takes live data.
                    if (sync_cnt_r == SYNC_LAST) begin
                        state_s = ST_ACTIVE;
                        shreg_s = sample_s;
                    end else begin
                        sync_cnt_s = sync_cnt_r + 4'd1;
                        shreg_s    = make_frame(IDLE_SYM);
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (frame_end_s) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    shreg_s   = sample_s;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = ST_RESET;
                shreg_s    = {FRAME_LEN{1'b0}};
                bit_cnt_s  = {CNT_W{1'b0}};
                sync_cnt_s = 4'd0;
            end
        endcase
    end

    // State, counters and shift register.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_r    <= ST_RESET;
            bit_cnt_r  <= {CNT_W{1'b0}};
            sync_cnt_r <= 4'd0;
            shreg_r    <= {FRAME_LEN{1'b0}};
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            sync_cnt_r <= sync_cnt_s;
            shreg_r    <= shreg_s;
        end
    end

    // Status outputs registered from next-state values so they align with the bit on data_out.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            load_req_r    <= 1'b0;
            frame_start_r <= 1'b0;
            active_r      <= 1'b0;
        end else begin
            load_req_r    <= (state_s != ST_RESET) && (bit_cnt_s == LAST_BIT);
            frame_start_r <= (state_s != ST_RESET) && (bit_cnt_s == {CNT_W{1'b0}});
            active_r      <= (state_s == ST_ACTIVE);
        end
    end

    assign data_out    = shreg_r[FRAME_LEN-1];
    assign load_req    = load_req_r;
    assign frame_start = frame_start_r;
    assign active      = active_r;

endmodule

// File: tb/tb_serializer_8b.sv
// Self-checking bench for serializer_8b: frame-level reference model, vector table,
// randomized traffic and an asynchronous mid-frame reset. Honours SERIALIZER_PARITY_EN.
module tb_serializer_8b;

    localparam int         SYNC_COUNT = 4;
    localparam logic [7:0] IDLE       = 8'hBC;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] exp;
    } vec_t;

    logic       clk_32f = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       load_req, data_out, frame_start, active;
    logic       load_req1, data_out1, frame_start1, active1;

    int total = 0;
    int bad   = 0;
    int t     = -1;
    logic [FL-1:0] cur_frame, cur_frame1, rx, last_rx;
    vec_t tbl[8];

    serializer_8b #(.IDLE_SYM(IDLE), .SYNC_COUNT(SYNC_COUNT)) dut (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .load_req(load_req), .data_out(data_out), .frame_start(frame_start), .active(active)
    );

    serializer_8b #(.IDLE_SYM(IDLE), .SYNC_COUNT(1)) dut1 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .load_req(load_req1), .data_out(data_out1), .frame_start(frame_start1), .active(active1)
    );

    always #5 clk_32f = ~clk_32f;

    function automatic logic [FL-1:0] frame_of(input logic [7:0] w);
`ifdef SERIALIZER_PARITY_EN
        frame_of = {w, ^w};
`else
        frame_of = w;
`endif
    endfunction

    task automatic cmp1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic cmpw(input string name, input logic [FL-1:0] act, input logic [FL-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0d)", name, act, exp, t);
        end
    endtask

    // Compare all outputs against the frame-level model for the current cycle.
    task automatic do_check();
        int pos;
        int frm;
        if (t < 0) begin
            cmp1("rst_data_out", data_out, 1'b0);
            cmp1("rst_load_req", load_req, 1'b0);
            cmp1("rst_frame_start", frame_start, 1'b0);
            cmp1("rst_active", active, 1'b0);
            cmp1("rst_active_sc1", active1, 1'b0);
        end else begin
            pos = t % FL;
            frm = t / FL;
            cmp1("data_out", data_out, cur_frame[FL-1-pos]);
            cmp1("load_req", load_req, pos == FL-1);
            cmp1("frame_start", frame_start, pos == 0);
            cmp1("active", active, frm >= SYNC_COUNT);
            cmp1("data_out_sc1", data_out1, cur_frame1[FL-1-pos]);
            cmp1("load_req_sc1", load_req1, pos == FL-1);
            cmp1("frame_start_sc1", frame_start1, pos == 0);
            cmp1("active_sc1", active1, frm >= 1);
            rx = {rx[FL-2:0], data_out};
            if (pos == FL-1) last_rx = rx;
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge();
        int f;
        if (!reset_L) begin
            t = -1;
        end else if (t < 0) begin
            t          = 0;
            cur_frame  = frame_of(IDLE);
            cur_frame1 = frame_of(IDLE);
        end else begin
            if (t % FL == FL-1) begin
                f          = t / FL + 1;
                cur_frame  = (f >= SYNC_COUNT && valid_in) ? frame_of(data_in) : frame_of(IDLE);
                cur_frame1 = valid_in ? frame_of(data_in) : frame_of(IDLE);
            end
            t++;
        end
    endtask

    task automatic step(input logic [7:0] d, input logic v);
        @(negedge clk_32f);
        do_check();
        data_in  = d;
        valid_in = v;
        @(posedge clk_32f);
        model_edge();
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{8'hFF, 1'b1, 8'hFF};
        tbl[2] = '{8'h00, 1'b1, 8'h00};
        tbl[3] = '{8'h3C, 1'b1, 8'h3C};
        tbl[4] = '{8'h55, 1'b0, IDLE};
        tbl[5] = '{IDLE,  1'b1, IDLE};
        tbl[6] = '{8'h07, 1'b1, 8'h07};
        tbl[7] = '{8'h81, 1'b0, IDLE};

        reset_L    = 1'b0;
        data_in    = 8'h00;
        valid_in   = 1'b0;
        rx         = '0;
        last_rx    = '0;
        cur_frame  = '0;
        cur_frame1 = '0;

        repeat (3) step(8'h00, 1'b0);
        #1 reset_L = 1'b1;

        // Sync preamble with idle input; stops just before the first live sample cycle.
        repeat (SYNC_COUNT * FL) step(8'($urandom), 1'b0);

        // Table vectors back-to-back; mid-frame cycles carry random junk and valid pulses.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].d, tbl[i].v);
            if (i == 0) cmpw("sync_frame", last_rx, frame_of(IDLE));
            else        cmpw("vec_frame", last_rx, frame_of(tbl[i-1].exp));
            repeat (FL-1) step(8'($urandom), 1'($urandom_range(0, 1)));
        end
        step(8'h00, 1'b0);
        cmpw("vec_frame", last_rx, frame_of(tbl[7].exp));

        repeat (300) step(8'($urandom), 1'($urandom_range(0, 1)));

        // Asynchronous reset at bit_cnt==3 of an A5 frame.
        while (t % FL != FL-1) step(8'($urandom), 1'b0);
        step(8'hA5, 1'b1);
        repeat (3) step(8'($urandom), 1'b0);
        @(negedge clk_32f);
        do_check();
        #2 reset_L = 1'b0;
        #1;
        cmp1("async_rst_data_out", data_out, 1'b0);
        cmp1("async_rst_load_req", load_req, 1'b0);
        cmp1("async_rst_frame_start", frame_start, 1'b0);
        cmp1("async_rst_active", active, 1'b0);
        @(posedge clk_32f);
        model_edge();
        repeat (2) step(8'h00, 1'b0);
        #1 reset_L = 1'b1;

        // Valid data offered throughout the repeated preamble must be ignored by the main instance.
        repeat ((SYNC_COUNT + 3) * FL) step(8'($urandom), 1'b1);
        repeat (50) step(8'($urandom), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serializer_8b.md
Name: serializer_8b

Overview:
- Output stage placed directly downstream of the 4-to-2 / 2-to-1 mux tree.
- Converts each 8-bit word plus its valid bit into a serial bit stream, MSB first, on the fast clock.
- Inserts comma/idle symbols when the word is not valid, and sends a fixed sync preamble after reset.
- Requests each new word with a one-cycle load strobe so the upstream mux stage can present data in time.

Parameters:
- IDLE_SYM, 8'hBC, symbol sent when valid_in is low at load time, and during sync.
- SYNC_COUNT, 4, number of IDLE_SYM frames sent after reset before data is accepted (range 1..15).

Ports:
- clk_32f  input  1  serial bit clock; every flop is clocked on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  8  parallel word from the upstream mux stage.
- valid_in  input  1  qualifies data_in.
- load_req  output  1  high during the last bit cycle of a frame; data_in/valid_in are sampled at the closing edge of that cycle.
- data_out  output  1  serial bit.
- frame_start  output  1  high during the bit cycle that carries bit 7 of a frame.
- active  output  1  high while the state machine is in ACTIVE.

Behaviour:
- Reset values (asynchronous, while reset_L=0): data_out=0, load_req=0, frame_start=0, active=0, bit_cnt=0, sync_cnt=0, shift register=0, state=RESET.
- Counter: bit_cnt is 3 bits; it counts 0..7 and wraps from 7 to 0 every frame. FRAME_LEN=8.
- Frame timing:
  - bit_cnt==0: frame_start=1, data_out=shreg[7].
  - bit_cnt==k: data_out=shreg[7-k].
  - load_req=1 exactly when bit_cnt==FRAME_LEN-1 and state != RESET.
- State machine, states RESET, SYNC, ACTIVE:
  - RESET: first clock edge after reset_L rises → go to SYNC and load shreg=IDLE_SYM, bit_cnt=0.
  - SYNC: when a frame completes (load_req edge), increment sync_cnt. When sync_cnt reaches SYNC_COUNT-1 at that edge, go to ACTIVE and load the sampled word. Otherwise reload IDLE_SYM; data_in is ignored.
  - ACTIVE: at each load_req edge, shreg = valid_in ? data_in : IDLE_SYM. active=1 starting the cycle after the transition.
- Latency: a word sampled at a load_req edge has its bit 7 on data_out in the next cycle (frame_start=1); its bit 0 appears 8 cycles after the sample edge.
- Frames are back-to-back; no gap cycles between them.
- Boundary cases:
  - valid_in toggling mid-frame has no effect; only the sample edge matters.
  - data_in=IDLE_SYM with valid_in=1 is transmitted unchanged; no disambiguation is done.
  - reset_L asserted mid-frame clears everything immediately, without waiting for a clock. After release, the full sync preamble (SYNC_COUNT frames) repeats.
  - SYNC_COUNT=1: exactly one idle frame is sent, then the block enters ACTIVE.
- data_out is driven from a register; there is no combinational path from data_in to data_out.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- When defined:
  - FRAME_LEN=9, and bit_cnt is 4 bits wrapping 8→0.
  - The bit at bit_cnt==8 is the even-parity bit (XOR of the 8 frame bits), including on idle frames.
  - load_req is high at bit_cnt==8.
  - Latency from sample edge to last bit becomes 9 cycles.
- When not defined: 8-bit frames, no parity logic synthesized.

Test Plan:
- Reset, then idle (valid_in=0), SYNC_COUNT=4 → after the first edge, 4 frames of 10111100 serially, active rises after the 4th load_req, and 0xBC frames continue.
- After sync, data_in=8'hA5 with valid_in=1 at a load_req edge → next 8 bits are 1,0,1,0,0,1,0,1, frame_start=1 on the first.
- Back-to-back words 8'hFF, 8'h00, 8'h3C → 24 contiguous bits 11111111 00000000 00111100, with load_req every 8th cycle.
- valid_in=0 with data_in=8'h55 at the sample edge → frame is 0xBC, not 0x55. valid_in pulsed high mid-frame → ignored.
- reset_L pulled low at bit_cnt=3 during frame 8'hA5 → outputs are 0 immediately without a clock. After release, 4 sync frames precede any data and active=0 during sync.
- With SERIALIZER_PARITY_EN: word 8'hA5 → 9 bits 101001010 (parity 0). Word 8'h07 → parity bit 1. load_req period is 9 cycles.
